// File: rtl/wb_stream_initiator_pkg.sv
// rtl/wb_stream_initiator_pkg.sv - shared encodings for the byte-stream Wishbone initiator
package wb_stream_initiator_pkg;

    typedef enum logic [2:0] {
        ST_CMD    = 3'd0,
        ST_ADDR   = 3'd1,
        ST_DATA   = 3'd2,
        ST_BUS    = 3'd3,
        ST_STATUS = 3'd4,
        ST_RDATA  = 3'd5
    } state_e;

    localparam logic [7:0] STS_ACK     = 8'h00;
    localparam logic [7:0] STS_ERR     = 8'h01;
    localparam logic [7:0] STS_RTY     = 8'h02;
    localparam logic [7:0] STS_TIMEOUT = 8'h03;
    localparam logic [7:0] STS_BADCMD  = 8'h04;

    localparam int CMD_WE_BIT   = 7;
    localparam int CMD_RSV_MSB  = 6;
    localparam int CMD_RSV_LSB  = 4;
    localparam int CMD_SEL_MSB  = 3;
    localparam int CMD_SEL_LSB  = 0;

    function automatic logic cmd_is_bad(input logic [7:0] cmd);
        return |cmd[CMD_RSV_MSB:CMD_RSV_LSB];
    endfunction

endpackage

// File: rtl/wb_stream_initiator.sv
// rtl/wb_stream_initiator.sv - byte-stream command frames to single-beat Wishbone classic cycles
module wb_stream_initiator
    import wb_stream_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    output logic [3:0]  sel_o,
    output logic        we_o,
    output logic        stb_o,
    output logic        cyc_o,
    input  logic        ack_i,
    input  logic        err_i,
    input  logic        rty_i,
    output logic        busy_o
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  status_q, status_d;
    logic [15:0] tmo_q, tmo_d;
    logic        cyc_q, cyc_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_CMD;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            rdata_q  <= '0;
            status_q <= '0;
            tmo_q    <= '0;
            cyc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            rdata_q  <= rdata_d;
            status_q <= status_d;
            tmo_q    <= tmo_d;
            cyc_q    <= cyc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        sel_d    = sel_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        rdata_d  = rdata_q;
        status_d = status_q;
        tmo_d    = tmo_q;
        cyc_d    = cyc_q;
        case (state_q)
            ST_CMD: begin
                if (rx_valid_i) begin
                    if (cmd_is_bad(rx_data_i)) begin
                        status_d = STS_BADCMD;
                        state_d  = ST_STATUS;
                    end else begin
                        we_d    = rx_data_i[CMD_WE_BIT];
                        sel_d   = rx_data_i[CMD_SEL_MSB:CMD_SEL_LSB];
                        cnt_d   = '0;
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                if (rx_valid_i) begin
                    adr_d[{cnt_q, 3'b000} +: 8] = rx_data_i;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (we_q) begin
                            state_d = ST_DATA;
                        end else begin
                            state_d = ST_BUS;
                            cyc_d   = 1'b1;
                            tmo_d   = '0;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (rx_valid_i) begin
                    dat_d[{cnt_q, 3'b000} +: 8] = rx_data_i;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = ST_BUS;
                        cyc_d   = 1'b1;
                        tmo_d   = '0;
                    end
                end
            end
            ST_BUS: begin
                tmo_d = tmo_q + 16'd1;
                cnt_d = '0;
                // A termination in the expiry cycle still beats the timeout.
                if (err_i || rty_i || ack_i) begin
                    cyc_d   = 1'b0;
                    state_d = ST_STATUS;
                    if (err_i) begin
                        status_d = STS_ERR;
                    end else if (rty_i) begin
                        status_d = STS_RTY;
                    end else begin
                        status_d = STS_ACK;
                        if (!we_q) rdata_d = dat_i;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    cyc_d    = 1'b0;
                    status_d = STS_TIMEOUT;
                    state_d  = ST_STATUS;
                end
            end
            ST_STATUS: begin
                if (tx_ready_i) begin
                    cnt_d   = '0;
                    state_d = (status_q == STS_ACK && !we_q) ? ST_RDATA : ST_CMD;
                end
            end
            ST_RDATA: begin
                if (tx_ready_i) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = ST_CMD;
                end
            end
            default: begin
                state_d = ST_CMD;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        tx_data_o = 8'h00;
        if (state_q == ST_STATUS) begin
            tx_data_o = status_q;
        end else if (state_q == ST_RDATA) begin
            tx_data_o = rdata_q[{cnt_q, 3'b000} +: 8];
        end
    end

    assign rx_ready_o = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DATA);
    assign tx_valid_o = (state_q == ST_STATUS) || (state_q == ST_RDATA);
    assign busy_o     = (state_q != ST_CMD);
    assign cyc_o      = cyc_q;
    assign stb_o      = cyc_q;
    assign adr_o      = adr_q;
    assign dat_o      = dat_q;
    assign sel_o      = sel_q;
    assign we_o       = we_q;

endmodule

// File: tb/tb_wb_stream_initiator.sv
// tb/tb_wb_stream_initiator.sv - directed self-checking bench for wb_stream_initiator
module tb_wb_stream_initiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [31:0] adr, dat_w, dat_r;
    logic [3:0]  sel;
    logic        we, stb, cyc, ack, err, rty, busy;

    logic        err_en = 1'b0;
    logic        rty_en = 1'b0;
    logic [31:0] mem_word = 32'h0000_0000;
    logic [31:0] gpio = 32'hAABB_CC00;
    logic [31:0] cap_adr, cap_dat;
    logic [3:0]  cap_sel;
    logic        cap_we;
    logic        hit_mem, hit_gpio;

    int checks = 0;
    int failures = 0;

    wb_stream_initiator #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .adr_o(adr), .dat_o(dat_w), .dat_i(dat_r), .sel_o(sel), .we_o(we),
        .stb_o(stb), .cyc_o(cyc), .ack_i(ack), .err_i(err), .rty_i(rty),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    assign hit_mem  = (adr[31:28] == 4'h1);
    assign hit_gpio = (adr[31:28] == 4'h4);
    assign ack   = cyc && stb && (hit_mem || hit_gpio);
    assign err   = cyc && stb && err_en;
    assign rty   = cyc && stb && rty_en;
    assign dat_r = hit_gpio ? gpio : mem_word;

    always @(posedge clk) begin
        if (cyc && stb && ack) begin
            cap_adr <= adr;
            cap_dat <= dat_w;
            cap_sel <= sel;
            cap_we  <= we;
            if (we && !err && !rty) begin
                for (int i = 0; i < 4; i++) begin
                    if (sel[i] && hit_mem)  mem_word[i*8 +: 8] <= dat_w[i*8 +: 8];
                    if (sel[i] && hit_gpio) gpio[i*8 +: 8]     <= dat_w[i*8 +: 8];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rx_handshake_bound", 32'(n < 50), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic recv_byte(output logic [7:0] b);
        int n = 0;
        tx_ready = 1'b1;
        while (!tx_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("tx_handshake_bound", 32'(n < 50), 32'd1);
        b = tx_data;
        @(negedge clk);
        tx_ready = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d);
        send_byte(cmd);
        for (int i = 0; i < 4; i++) send_byte(a[i*8 +: 8]);
        if (cmd[7]) for (int i = 0; i < 4; i++) send_byte(d[i*8 +: 8]);
    endtask

    initial begin
        logic [7:0] b;
        int n;

        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cyc", 32'(cyc), 32'd0);
        check("rst_stb", 32'(stb), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        check("rst_adr", adr, 32'h0);
        check("rst_dat", dat_w, 32'h0);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Full-word write to memory
        send_frame(8'h8F, 32'h1000_0000, 32'hDEAD_BEEF);
        recv_byte(b);
        check("wr_status", 32'(b), 32'h00);
        check("wr_cap_adr", cap_adr, 32'h1000_0000);
        check("wr_cap_dat", cap_dat, 32'hDEAD_BEEF);
        check("wr_cap_sel", 32'(cap_sel), 32'hF);
        check("wr_cap_we", 32'(cap_we), 32'd1);
        check("wr_mem", mem_word, 32'hDEAD_BEEF);
        check("wr_no_data_tx", 32'(tx_valid), 32'd0);
        check("wr_idle", 32'(busy), 32'd0);

        // Read back, with minimum-latency check
        send_frame(8'h0F, 32'h1000_0000, 32'h0);
        check("rd_cyc_first", 32'(cyc), 32'd1);
        @(negedge clk);
        check("rd_latency_valid", 32'(tx_valid), 32'd1);
        check("rd_cyc_fell", 32'(cyc), 32'd0);
        recv_byte(b); check("rd_status", 32'(b), 32'h00);
        recv_byte(b); check("rd_b0", 32'(b), 32'hEF);
        recv_byte(b); check("rd_b1", 32'(b), 32'hBE);
        recv_byte(b); check("rd_b2", 32'(b), 32'hAD);
        recv_byte(b); check("rd_b3", 32'(b), 32'hDE);
        check("rd_done", 32'(busy), 32'd0);

        // GPIO byte write
        send_frame(8'h81, 32'h4000_0000, 32'h0000_0003);
        recv_byte(b);
        check("gpio_status", 32'(b), 32'h00);
        check("gpio_sel", 32'(cap_sel), 32'h1);
        check("gpio_adr", cap_adr, 32'h4000_0000);
        check("gpio_leds", 32'(gpio[1:0]), 32'h3);
        check("gpio_word", gpio, 32'hAABB_CC03);

        // Unmapped read times out after exactly 8 bus cycles
        send_frame(8'h0F, 32'h8000_0000, 32'h0);
        n = 0;
        while (cyc && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("tmo_cyc_cycles", 32'(n), 32'd8);
        recv_byte(b);
        check("tmo_status", 32'(b), 32'h03);

        // ack with err: err wins, no data bytes
        err_en = 1'b1;
        send_frame(8'h0F, 32'h1000_0000, 32'h0);
        recv_byte(b);
        err_en = 1'b0;
        check("err_status", 32'(b), 32'h01);
        check("err_no_data", 32'(tx_valid), 32'd0);

        // ack with rty: rty wins
        rty_en = 1'b1;
        send_frame(8'h0F, 32'h1000_0000, 32'h0);
        recv_byte(b);
        rty_en = 1'b0;
        check("rty_status", 32'(b), 32'h02);
        check("rty_no_data", 32'(tx_valid), 32'd0);

        // Bad command
        send_byte(8'h10);
        check("bad_rx_ready_low", 32'(rx_ready), 32'd0);
        check("bad_tx_data", 32'(tx_data), 32'h04);
        recv_byte(b);
        check("bad_status", 32'(b), 32'h04);
        check("bad_rx_ready_back", 32'(rx_ready), 32'd1);
        check("bad_idle", 32'(busy), 32'd0);

        // Backpressure during RDATA
        send_frame(8'h0F, 32'h1000_0000, 32'h0);
        recv_byte(b);
        check("bp_status", 32'(b), 32'h00);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(tx_valid), 32'd1);
            check("bp_data_stable", 32'(tx_data), 32'hEF);
            @(negedge clk);
        end
        recv_byte(b); check("bp_b0", 32'(b), 32'hEF);
        recv_byte(b); check("bp_b1", 32'(b), 32'hBE);
        recv_byte(b); check("bp_b2", 32'(b), 32'hAD);
        recv_byte(b); check("bp_b3", 32'(b), 32'hDE);

        // Reset during BUS
        send_frame(8'h0F, 32'h8000_0000, 32'h0);
        check("rst_mid_cyc_before", 32'(cyc), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_cyc", 32'(cyc), 32'd0);
        check("rst_mid_stb", 32'(stb), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
        @(negedge clk);
        send_frame(8'h81, 32'h4000_0000, 32'h0000_000C);
        recv_byte(b);
        check("post_rst_status", 32'(b), 32'h00);
        check("post_rst_gpio", gpio, 32'hAABB_CC0C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
